// File: rtl/ntt_pkg.sv
// Shared constants, FSM state encoding and address helpers for the NTT twiddle sequencer.
// Pure package: no logic, no latency, no flow control.
// Address helpers are combinational and are registered by their users.
package ntt_pkg;

    localparam int LOGN       = 12;
    localparam int AW         = 13;
    localparam int ROM_LAT    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int KW         = LOGN - 1;
    localparam int K_LAST     = (1 << (LOGN - 1)) - 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        FLUSH,
        DONE
    } state_t;

    // Inverse transforms walk the stages from the top down.
    function automatic logic [3:0] stage_of(input logic [3:0] pos, input logic fwd);
        return fwd ? pos : 4'(LOGN - 1) - pos;
    endfunction

    // Twiddle index for butterfly k of stage s: (1<<s) + (k >> (LOGN-1-s)).
    function automatic logic [AW-1:0] tw_addr(input logic [KW-1:0] k, input logic [3:0] s);
        logic [LOGN-1:0] m;
        logic [LOGN-1:0] off;
        logic [3:0]      sh;
        sh  = 4'(LOGN - 1) - s;
        m   = LOGN'(1) << s;
        off = {1'b0, k} >> sh;
        return AW'(m + off);
    endfunction

endpackage

// File: rtl/ntt_valid_pipe.sv
// Tags ROM read data as valid: fixed-depth shift register of the address-valid flag.
// Latency DEPTH cycles.
// No backpressure: shifts every cycle because the ROM outputs cannot stall.
module ntt_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_twiddle_addr_gen.sv
// Walks all NTT stages issuing two twiddle ROM addresses per cycle, with a ROM-latency-aligned valid.
// Latency: first address pair 1 cycle after start; done LOGN*N/4 + (LOGN-1)*GAP + ROM_LAT edges after start.
// Backpressure: hold sampled at each edge stalls issue in RUN (addresses frozen); GAP/FLUSH ignore it.
module ntt_twiddle_addr_gen
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    instruction,
    input  logic          mod_sel,
    input  logic          hold,
    output logic [7:0]    instr_q,
    output logic          mod_sel_q,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_n,
    output logic          addr_valid,
    output logic          tw_valid,
    output logic [3:0]    stage,
    output logic          busy,
    output logic          done
);

    state_t          state;
    logic [KW-1:0]   k;          // butterfly index of the pair last issued
    logic [3:0]      pos;        // stage position in issue order
    logic [2:0]      gap_cnt;
    logic [2:0]      flush_cnt;

    logic [KW-1:0]   k_iss;
    logic [3:0]      s_iss;
    logic [AW-1:0]   addr_a_d;
    logic [AW-1:0]   addr_n_d;

    // Pair that would be issued at the coming edge, depending on where we are.
    always_comb begin
        k_iss = '0;
        s_iss = stage;
        case (state)
            IDLE:    s_iss = stage_of(4'd0, instruction[0]);
            RUN:     k_iss = k + KW'(2);
            GAP:     s_iss = stage_of(pos + 4'd1, instr_q[0]);
            default: ;
        endcase
    end

    assign addr_a_d = tw_addr(k_iss, s_iss);
    assign addr_n_d = tw_addr(k_iss | KW'(1), s_iss);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            pos        <= '0;
            gap_cnt    <= '0;
            flush_cnt  <= '0;
            instr_q    <= '0;
            mod_sel_q  <= 1'b0;
            addr_a     <= '0;
            addr_n     <= '0;
            addr_valid <= 1'b0;
            stage      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        instr_q    <= instruction;
                        mod_sel_q  <= mod_sel;
                        busy       <= 1'b1;
                        state      <= RUN;
                        k          <= '0;
                        pos        <= '0;
                        stage      <= s_iss;
                        addr_a     <= addr_a_d;
                        addr_n     <= addr_n_d;
                        addr_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (hold) begin
                        addr_valid <= 1'b0;
                    end else if (k == KW'(K_LAST)) begin
                        addr_valid <= 1'b0;
                        if (pos == 4'(LOGN - 1)) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        k          <= k_iss;
                        addr_a     <= addr_a_d;
                        addr_n     <= addr_n_d;
                        addr_valid <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 3'(GAP_CYCLES - 1)) begin
                        state      <= RUN;
                        pos        <= pos + 4'd1;
                        k          <= '0;
                        stage      <= s_iss;
                        addr_a     <= addr_a_d;
                        addr_n     <= addr_n_d;
                        addr_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'(ROM_LAT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ntt_valid_pipe #(
        .DEPTH (ROM_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (addr_valid),
        .dout  (tw_valid)
    );

endmodule

// File: tb/tb_ntt_twiddle_addr_gen.sv
// Directed bench for the twiddle address sequencer: full forward/inverse walks, hold, busy-start, reset.
module tb_ntt_twiddle_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  instruction;
    logic        mod_sel;
    logic        hold;
    logic [7:0]  instr_q;
    logic        mod_sel_q;
    logic [12:0] addr_a;
    logic [12:0] addr_n;
    logic        addr_valid;
    logic        tw_valid;
    logic [3:0]  stage;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_fail;

    // per-run statistics gathered by run_op
    int n_av, n_tw, n_done, done_cyc, first_cyc;
    int addr_err, s0_bad, hold_err, busy_err, instr_err, tw_err;
    logic [3:0]  first_stage, last_stage;
    logic [12:0] first_a, first_n, last_a, last_n;
    logic [12:0] s11_first_a, s11_first_n, s11_last_a, s11_last_n;
    logic        s11_seen;

    ntt_twiddle_addr_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .mod_sel     (mod_sel),
        .hold        (hold),
        .instr_q     (instr_q),
        .mod_sel_q   (mod_sel_q),
        .addr_a      (addr_a),
        .addr_n      (addr_n),
        .addr_valid  (addr_valid),
        .tw_valid    (tw_valid),
        .stage       (stage),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start, then observes each cycle at the falling edge; cyc counts edges after acceptance.
    task automatic run_op(input logic fwd, input logic msel, input int hold_at, input int hold_len,
                          input int start2_at, input int budget);
        int cyc, p, idx, s, kk, ea, en;
        logic h1, h2;
        logic [12:0] prev_a, prev_n;
        logic [3:0]  prev_stage;
        logic [7:0]  instr_exp;
        n_av = 0; n_tw = 0; n_done = 0; done_cyc = -1; first_cyc = -1;
        addr_err = 0; s0_bad = 0; hold_err = 0; busy_err = 0; instr_err = 0; tw_err = 0;
        s11_seen = 1'b0; h1 = 1'b0; h2 = 1'b0;
        prev_a = '0; prev_n = '0; prev_stage = '0;
        instr_exp = {7'h52, fwd};
        @(negedge clk);
        instruction = instr_exp;
        mod_sel     = msel;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        instruction = ~instr_exp;
        mod_sel     = ~msel;
        cyc = 0;
        while (cyc < budget && n_done == 0) begin
            if (tw_valid !== h2) tw_err++;
            if (addr_valid === 1'b1) begin
                p   = n_av / 1024;
                idx = n_av % 1024;
                s   = fwd ? p : 11 - p;
                kk  = 2 * idx;
                ea  = (1 << s) + (kk >> (11 - s));
                en  = (1 << s) + ((kk + 1) >> (11 - s));
                if (stage !== 4'(s) || addr_a !== 13'(ea) || addr_n !== 13'(en)) addr_err++;
                if (n_av == 0) begin
                    first_cyc = cyc; first_stage = stage; first_a = addr_a; first_n = addr_n;
                end
                last_stage = stage; last_a = addr_a; last_n = addr_n;
                if (stage == 4'd0 && (addr_a !== 13'd1 || addr_n !== 13'd1)) s0_bad++;
                if (stage == 4'd11) begin
                    if (!s11_seen) begin
                        s11_first_a = addr_a; s11_first_n = addr_n; s11_seen = 1'b1;
                    end
                    s11_last_a = addr_a; s11_last_n = addr_n;
                end
                n_av++;
            end
            if (cyc > hold_at && cyc <= hold_at + hold_len) begin
                if (addr_valid !== 1'b0 || addr_a !== prev_a || addr_n !== prev_n || stage !== prev_stage)
                    hold_err++;
            end
            if (cyc > hold_at + 2 && cyc <= hold_at + hold_len + 2 && tw_valid !== 1'b0) hold_err++;
            if (tw_valid === 1'b1) n_tw++;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy !== ~done) busy_err++;
            if (instr_q !== instr_exp || mod_sel_q !== msel) instr_err++;
            h2 = h1; h1 = addr_valid;
            prev_a = addr_a; prev_n = addr_n; prev_stage = stage;
            hold  = (cyc >= hold_at && cyc < hold_at + hold_len);
            start = (cyc == start2_at);
            @(negedge clk);
            cyc++;
        end
        hold  = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; instruction = 8'h00; mod_sel = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({addr_a, addr_n, addr_valid, tw_valid, stage, busy, done, instr_q, mod_sel_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got a=%0d n=%0d av=%b tw=%b st=%0d busy=%b done=%b iq=%h mq=%b want all 0",
                     addr_a, addr_n, addr_valid, tw_valid, stage, busy, done, instr_q, mod_sel_q);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b av=%b want 0 0", busy, addr_valid);
        end
    endtask

    task automatic test_forward();
        run_op(1'b1, 1'b0, -1, 0, -1, 13000);
        n_cmp++; if (n_av != 12288) begin n_fail++; $display("FAIL fwd_av_count: got %0d want 12288", n_av); end
        n_cmp++; if (n_tw != 12288) begin n_fail++; $display("FAIL fwd_tw_count: got %0d want 12288", n_tw); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL fwd_done_count: got %0d want 1", n_done); end
        n_cmp++; if (done_cyc != 12334) begin n_fail++; $display("FAIL fwd_latency: got %0d want 12334", done_cyc); end
        n_cmp++; if (first_cyc != 0) begin n_fail++; $display("FAIL fwd_first_issue: got %0d want 0", first_cyc); end
        n_cmp++; if (first_stage !== 4'd0) begin n_fail++; $display("FAIL fwd_first_stage: got %0d want 0", first_stage); end
        n_cmp++; if (s0_bad != 0) begin n_fail++; $display("FAIL fwd_stage0_addr: got %0d bad pairs want 0", s0_bad); end
        n_cmp++;
        if (s11_first_a !== 13'd2048 || s11_first_n !== 13'd2049) begin
            n_fail++; $display("FAIL fwd_s11_first: got %0d/%0d want 2048/2049", s11_first_a, s11_first_n);
        end
        n_cmp++;
        if (s11_last_a !== 13'd4094 || s11_last_n !== 13'd4095) begin
            n_fail++; $display("FAIL fwd_s11_last: got %0d/%0d want 4094/4095", s11_last_a, s11_last_n);
        end
        n_cmp++; if (addr_err != 0) begin n_fail++; $display("FAIL fwd_addr_seq: got %0d errors want 0", addr_err); end
        n_cmp++; if (tw_err != 0) begin n_fail++; $display("FAIL fwd_tw_align: got %0d errors want 0", tw_err); end
        n_cmp++; if (busy_err != 0) begin n_fail++; $display("FAIL fwd_busy: got %0d errors want 0", busy_err); end
        n_cmp++; if (instr_err != 0) begin n_fail++; $display("FAIL fwd_latch: got %0d errors want 0", instr_err); end
        n_cmp++;
        if (instr_q !== 8'hA5 || mod_sel_q !== 1'b0) begin
            n_fail++; $display("FAIL fwd_latch_after_done: got %h/%b want a5/0", instr_q, mod_sel_q);
        end
    endtask

    task automatic test_inverse();
        run_op(1'b0, 1'b1, -1, 0, -1, 13000);
        n_cmp++;
        if (first_stage !== 4'd11 || first_a !== 13'd2048 || first_n !== 13'd2049) begin
            n_fail++; $display("FAIL inv_first: got st=%0d %0d/%0d want st=11 2048/2049", first_stage, first_a, first_n);
        end
        n_cmp++;
        if (last_stage !== 4'd0 || last_a !== 13'd1 || last_n !== 13'd1) begin
            n_fail++; $display("FAIL inv_last: got st=%0d %0d/%0d want st=0 1/1", last_stage, last_a, last_n);
        end
        n_cmp++; if (instr_err != 0) begin n_fail++; $display("FAIL inv_latch: got %0d errors want 0", instr_err); end
        n_cmp++; if (addr_err != 0) begin n_fail++; $display("FAIL inv_addr_seq: got %0d errors want 0", addr_err); end
        n_cmp++;
        if (n_av != 12288 || n_tw != 12288 || n_done != 1) begin
            n_fail++; $display("FAIL inv_counts: got av=%0d tw=%0d done=%0d want 12288 12288 1", n_av, n_tw, n_done);
        end
        n_cmp++; if (done_cyc != 12334) begin n_fail++; $display("FAIL inv_latency: got %0d want 12334", done_cyc); end
    endtask

    task automatic test_hold();
        run_op(1'b1, 1'b0, 5500, 3, -1, 13000);
        n_cmp++; if (hold_err != 0) begin n_fail++; $display("FAIL hold_freeze: got %0d errors want 0", hold_err); end
        n_cmp++; if (done_cyc != 12337) begin n_fail++; $display("FAIL hold_latency: got %0d want 12337", done_cyc); end
        n_cmp++; if (addr_err != 0) begin n_fail++; $display("FAIL hold_addr_seq: got %0d errors want 0", addr_err); end
        n_cmp++;
        if (n_av != 12288 || n_tw != 12288) begin
            n_fail++; $display("FAIL hold_counts: got av=%0d tw=%0d want 12288 12288", n_av, n_tw);
        end
        n_cmp++; if (tw_err != 0) begin n_fail++; $display("FAIL hold_tw_align: got %0d errors want 0", tw_err); end
    endtask

    task automatic test_start_while_busy();
        run_op(1'b1, 1'b0, -1, 0, 3000, 13000);
        n_cmp++; if (instr_err != 0) begin n_fail++; $display("FAIL busy_start_latch: got %0d errors want 0", instr_err); end
        n_cmp++; if (done_cyc != 12334) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 12334", done_cyc); end
        n_cmp++; if (addr_err != 0) begin n_fail++; $display("FAIL busy_start_addr: got %0d errors want 0", addr_err); end
    endtask

    task automatic test_reset_mid();
        int dn;
        run_op(1'b1, 1'b0, -1, 0, -1, 500);
        n_cmp++; if (n_done != 0) begin n_fail++; $display("FAIL midrst_pre_done: got %0d want 0", n_done); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({addr_a, addr_n, addr_valid, tw_valid, stage, busy, done, instr_q, mod_sel_q} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got a=%0d n=%0d av=%b tw=%b st=%0d busy=%b done=%b iq=%h want all 0",
                     addr_a, addr_n, addr_valid, tw_valid, stage, busy, done, instr_q);
        end
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done !== 1'b0 || tw_valid !== 1'b0) dn++;
        n_cmp++; if (dn != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dn); end
        run_op(1'b1, 1'b1, -1, 0, -1, 13000);
        n_cmp++;
        if (first_cyc != 0 || first_stage !== 4'd0 || first_a !== 13'd1 || first_n !== 13'd1) begin
            n_fail++;
            $display("FAIL midrst_restart: got cyc=%0d st=%0d %0d/%0d want 0 0 1/1", first_cyc, first_stage, first_a, first_n);
        end
        n_cmp++;
        if (n_av != 12288 || n_done != 1 || done_cyc != 12334) begin
            n_fail++; $display("FAIL midrst_rerun: got av=%0d done=%0d at %0d want 12288 1 12334", n_av, n_done, done_cyc);
        end
        n_cmp++; if (instr_err != 0) begin n_fail++; $display("FAIL midrst_latch: got %0d errors want 0", instr_err); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_forward();
        test_inverse();
        test_hold();
        test_start_while_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
